// File: rtl/uart_block_packer_if.sv
// Valid/ready byte or block channel shared by the packer's input and output sides.
interface uart_block_packer_if #(
    parameter int W = 8
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_block_packer.sv
// Packs received UART bytes into 128-bit blocks for the AES core.
// The first byte lands in the top byte lane. A partial block is dropped
// when en falls or when the gap between bytes exceeds timeout_cycles.
module uart_block_packer #(
    parameter int TO_W   = 24,
    parameter int NBYTES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    uart_block_packer_if.slave  s_axis,
    uart_block_packer_if.master m_axis,
    input  logic [TO_W-1:0]     timeout_cycles,
    output logic [4:0]          byte_cnt,
    output logic                timeout_err
);
    localparam int         DATA_W   = 8 * NBYTES;
    localparam logic [4:0] LAST_IDX = 5'(NBYTES - 1);

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL,
        OUT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [4:0]        cnt_q;
    logic [DATA_W-1:0] data_q;
    logic [TO_W-1:0]   timer_q;
    logic [TO_W-1:0]   timer_inc;
    logic              err_q;
    logic              accept;
    logic              expire;

    assign accept    = s_axis.tvalid && s_axis.tready;
    // The timer saturates at all-ones instead of wrapping back to zero.
    assign timer_inc = (&timer_q) ? timer_q : timer_q + TO_W'(1);
    // An accepted byte takes priority over expiry. Dropping en takes priority over both.
    assign expire    = (state_q == FILL) && en && !accept &&
                       (timeout_cycles != '0) && (timer_inc >= timeout_cycles);

    // State register.
    // NOTE: sequential state uses non-blocking assignments. Every register then samples pre-edge values, whatever the block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision: fill, emit a full block, or discard a partial one.
    always_comb begin
        // NOTE: assign a default first, so no path leaves state_d unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            FILL_IDLE: begin
                if (accept) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!en) begin
                    state_d = FILL_IDLE;
                end else if (accept) begin
                    state_d = (cnt_q == LAST_IDX) ? OUT : FILL;
                end else if (expire) begin
                    state_d = FILL_IDLE;
                end
            end
            OUT: begin
                if (m_axis.tready) begin
                    state_d = FILL_IDLE;
                end
            end
            default: state_d = FILL_IDLE;
        endcase
    end

    // Handshake outputs, decoded from the current state. Ready is also forced low while in reset.
    always_comb begin
        s_axis.tready = en && !rst && (state_q != OUT);
        m_axis.tvalid = (state_q == OUT);
    end

    // Byte lane writes, fill count, inter-byte timer and timeout pulse.
    // NOTE: the block register is reset on purpose. Only stale lanes survive a discard, and reset must drive tdata to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            data_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= expire;
            if (accept) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (cnt_q == 5'(i)) begin
                        data_q[8*(NBYTES-1-i) +: 8] <= s_axis.tdata;
                    end
                end
                cnt_q <= cnt_q + 5'd1;
            end else if (state_d == FILL_IDLE) begin
                cnt_q <= '0;
            end
            // The timer runs only while a partial block stays in FILL without a new byte.
            if ((state_q == FILL) && (state_d == FILL) && !accept) begin
                timer_q <= timer_inc;
            end else begin
                timer_q <= '0;
            end
        end
    end

    assign m_axis.tdata = data_q;
    assign byte_cnt     = cnt_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_uart_block_packer.sv
// Self-checking bench for uart_block_packer.
// A byte-queue reference model predicts every output on every cycle.
module tb_uart_block_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic [23:0] tc;
    logic [4:0]  byte_cnt;
    logic        timeout_err;

    uart_block_packer_if #(.W(8))   s_if ();
    uart_block_packer_if #(.W(128)) m_if ();

    uart_block_packer #(.TO_W(24), .NBYTES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .timeout_cycles (tc),
        .byte_cnt       (byte_cnt),
        .timeout_err    (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the bytes held so far, a pending output block, and the idle cycles since the last byte.
    logic [7:0]   m_q[$];
    bit           m_valid;
    logic [127:0] m_block;
    bit           m_err;
    int           m_idle;

    function automatic void model_clear();
        m_q.delete();
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_idle  = 0;
    endfunction

    function automatic void model_step(input logic e, input logic tv, input logic [7:0] d, input logic mr);
        m_err = 1'b0;
        if (m_valid) begin
            if (mr) m_valid = 1'b0;
        end else if (e && tv) begin
            m_q.push_back(d);
            m_idle = 0;
            if (m_q.size() == 16) begin
                for (int i = 0; i < 16; i++) m_block[127-8*i -: 8] = m_q[i];
                m_valid = 1'b1;
                m_q.delete();
            end
        end else if (m_q.size() != 0) begin
            if (!e) begin
                m_q.delete();
            end else begin
                m_idle++;
                if (tc != 0 && m_idle >= int'(tc)) begin
                    m_q.delete();
                    m_err = 1'b1;
                end
            end
        end
    endfunction

    logic       s_tready;
    logic [4:0] s_cnt;
    logic       s_tvalid;

    // One clock cycle. Called at a falling edge. It drives the inputs, checks the outputs against the model, and advances to the next falling edge.
    task automatic cyc(input logic e, input logic tv, input logic [7:0] d, input logic mr);
        en          = e;
        s_if.tvalid = tv;
        s_if.tdata  = d;
        m_if.tready = mr;
        #1;
        s_tready = s_if.tready;
        s_cnt    = byte_cnt;
        s_tvalid = m_if.tvalid;
        check("tready",      s_if.tready, e && !m_valid);
        check("tvalid",      m_if.tvalid, m_valid);
        check("byte_cnt",    byte_cnt, m_valid ? 16 : m_q.size());
        check("timeout_err", timeout_err, m_err);
        if (m_valid) check("tdata", m_if.tdata, m_block);
        model_step(e, tv, d, mr);
        @(negedge clk);
    endtask

    task automatic send(input int n, input int base, input logic mr);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 8'(base + i), mr);
    endtask

    // Raises reset between clock edges and checks that every output clears without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_tready"}, s_if.tready, 1'b0);
        check({tag, "_tvalid"}, m_if.tvalid, 1'b0);
        check({tag, "_cnt"},    byte_cnt, 5'd0);
        check({tag, "_err"},    timeout_err, 1'b0);
        check({tag, "_tdata"},  m_if.tdata, 128'h0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       e;
        logic       tv;
        logic [7:0] d;
        logic       mr;
        logic       x_tready;
        logic [4:0] x_cnt;
        logic       x_tvalid;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;

        rst = 1'b1; en = 1'b1; tc = '0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b0;
        model_clear();
        #1;
        check("rst_tready", s_if.tready, 1'b0);
        check("rst_tvalid", m_if.tvalid, 1'b0);
        check("rst_cnt",    byte_cnt, 5'd0);
        check("rst_err",    timeout_err, 1'b0);
        check("rst_tdata",  m_if.tdata, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table of short vectors: enable gating, counting, and a discard when en falls.
        tbl[0] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 5'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 5'd0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 5'd1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd2, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 5'd2, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].e, tbl[i].tv, tbl[i].d, tbl[i].mr);
            check("tbl_tready", s_tready, tbl[i].x_tready);
            check("tbl_cnt",    s_cnt,    tbl[i].x_cnt);
            check("tbl_tvalid", s_tvalid, tbl[i].x_tvalid);
        end

        // Bytes 0x00..0x0F sent back to back form one block. Valid appears one cycle after the 16th byte.
        send(16, 8'h00, 1'b1);
        check("blk0_valid", m_if.tvalid, 1'b1);
        check("blk0_cnt",   byte_cnt, 5'd16);
        check("blk0_data",  m_if.tdata, 128'h000102030405060708090a0b0c0d0e0f);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("blk0_cnt_after", byte_cnt, 5'd0);
        check("blk0_valid_after", m_if.tvalid, 1'b0);

        // Backpressure: the block is held stable and no byte is taken before the handshake.
        send(16, 8'h10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 8'hEE, 1'b0);
            check("bp_tready", s_tready, 1'b0);
            check("bp_tdata",  m_if.tdata, 128'h101112131415161718191a1b1c1d1e1f);
        end
        cyc(1'b1, 1'b1, 8'hEE, 1'b1);
        check("bp_hs_tready", s_tready, 1'b0);
        cyc(1'b1, 1'b1, 8'hEE, 1'b1);
        check("bp_17th_cnt", byte_cnt, 5'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        // Timeout: with a limit of 50, the error pulse comes exactly 50 cycles after the 5th byte.
        tc = 24'd50;
        send(5, 8'hA0, 1'b1);
        first = 0;
        for (int n = 1; n <= 60; n++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b1);
            if (timeout_err === 1'b1) begin
                first = n;
                break;
            end
        end
        check("to_latency", first, 50);
        check("to_cnt", byte_cnt, 5'd0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        send(16, 8'h30, 1'b1);
        check("to_blk_data", m_if.tdata, 128'h303132333435363738393a3b3c3d3e3f);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // A byte arriving in the same cycle the timer would expire wins.
        send(5, 8'hB0, 1'b1);
        for (int n = 0; n < 49; n++) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b1, 8'hB5, 1'b1);
        check("race_err", timeout_err, 1'b0);
        check("race_cnt", byte_cnt, 5'd6);
        for (int n = 0; n < 3; n++) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Dropping en discards a partial block silently. Reset mid-block and in OUT clears everything at once.
        send(7, 8'hC0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("en_drop_cnt", byte_cnt, 5'd0);
        check("en_drop_err", timeout_err, 1'b0);
        send(7, 8'hD0, 1'b1);
        async_reset("rst_mid");
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("rst_first_tready", s_tready, 1'b1);
        send(16, 8'h50, 1'b0);
        async_reset("rst_out");
        send(15, 8'h60, 1'b1);
        check("rst_no_early_blk", m_if.tvalid, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // A timeout limit of zero disables the timeout completely.
        tc = '0;
        send(3, 8'h70, 1'b1);
        for (int n = 0; n < 10000; n++) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("no_to_cnt", byte_cnt, 5'd3);
        check("no_to_err", timeout_err, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic against the model, with timeout disabled, short, and medium.
        for (int p = 0; p < 3; p++) begin
            tc = (p == 0) ? 24'd0 : ((p == 1) ? 24'd4 : 24'd9);
            for (int n = 0; n < 3000; n++) begin
                cyc($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 60,
                    8'($urandom), $urandom_range(0, 1) == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
